ram_port_arbiter: RTL

- Sequences and shares the single byte-addressed RAM port between two CPU requesters: instruction fetch (IF) and data memory (DM, covering LDR/STR and load/store multiple).
- Drives the RAM MFA/MOC handshake, checks alignment and arbitrates round-robin.
- Supports a DM lock so a load/store-multiple burst keeps the port across beats.
- Sits between the control unit / datapath and the ram instance inside the CPU.

---
 rtl/ram_port_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin IF/DM sharing of one RAM port with DM burst lock; ARB_TIMEOUT_EN adds an MOC timeout
module ram_port_arbiter #(
    parameter int AW             = 8,
    parameter int LOCK_MAX       = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    output logic          if_err,
    input  logic          dm_req,
    input  logic          dm_rw,
    input  logic [1:0]    dm_size,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    input  logic          dm_lock,
    output logic          dm_done,
    output logic [31:0]   dm_rdata,
    output logic          dm_err,
    output logic          ram_mfa,
    output logic          ram_rw,
    output logic [1:0]    ram_size,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    input  logic          ram_moc,
    output logic [1:0]    owner
);
    localparam int LW = $clog2(LOCK_MAX + 1);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    if (LOCK_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("ram_port_arbiter: LOCK_MAX and TIMEOUT_CYCLES must be at least 1");
    end
    state_t        state_q, state_d;
    logic          last_dm_q, last_dm_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [1:0]    owner_q, owner_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    size_q, size_d;
    logic          rw_q, rw_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          lock_win, grant_dm, grant_if, bad;
    logic [AW-1:0] g_addr;
    logic [1:0]    g_size;
    logic [31:0]   rd_fmt;
    logic [LW-1:0] lock_inc;
`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q, tmo_d;
`endif
    always_comb begin
        state_d   = state_q;
        last_dm_d = last_dm_q;
        lock_d    = lock_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        size_d    = size_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
`ifdef ARB_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        tmo_d     = tmo_q;
`endif
        // an active burst lock beats a pending fetch until LOCK_MAX beats have run
        lock_win = lock_q != '0 && dm_req && lock_q < LW'(LOCK_MAX);
        grant_dm = dm_req && (lock_win || !if_req || !last_dm_q);
        grant_if = if_req && !grant_dm;
        g_addr   = grant_dm ? dm_addr : if_addr;
        g_size   = grant_dm ? dm_size : 2'b10;
        bad      = g_size == 2'b11 || (g_size == 2'b10 && g_addr[1:0] != 2'b00) ||
                   (g_size == 2'b01 && g_addr[0]);
        rd_fmt   = size_q == 2'b00 ? {24'b0, ram_rdata[7:0]} :
                   size_q == 2'b01 ? {16'b0, ram_rdata[15:0]} : ram_rdata;
        lock_inc = lock_q == LW'(LOCK_MAX) ? lock_q : lock_q + LW'(1);
        case (state_q)
            IDLE: begin
                if (grant_dm || grant_if) begin
                    state_d   = bad ? RESP : ACCESS;
                    owner_d   = grant_dm ? 2'b10 : 2'b01;
                    last_dm_d = grant_dm;
                    addr_d    = g_addr;
                    size_d    = g_size;
                    rw_d      = grant_dm ? dm_rw : 1'b1;
                    wdata_d   = grant_dm ? dm_wdata : '0;
                    rdata_d   = '0;
                    err_d     = bad;
                    lock_d    = grant_if ? '0 : lock_q;
`ifdef ARB_TIMEOUT_EN
                    tcnt_d    = '0;
                    tmo_d     = 1'b0;
`endif
                end
            end
            ACCESS: begin
                if (ram_moc) begin
                    state_d = RESP;
                    rdata_d = rw_q ? rd_fmt : '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    lock_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
`ifdef ARB_TIMEOUT_EN
                if (owner_q == 2'b10) lock_d = (dm_lock && !tmo_q) ? lock_inc : '0;
`else
                if (owner_q == 2'b10) lock_d = dm_lock ? lock_inc : '0;
`endif
            end
        endcase
    end
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= IDLE;
            last_dm_q <= 1'b0;
            lock_q    <= '0;
            owner_q   <= '0;
            addr_q    <= '0;
            size_q    <= '0;
            rw_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_dm_q <= last_dm_d;
            lock_q    <= lock_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            rw_q      <= rw_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end
`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_d;
        end
    end
`endif
    assign ram_mfa   = state_q == ACCESS;
    assign ram_rw    = ram_mfa & rw_q;
    assign ram_size  = ram_mfa ? size_q : '0;
    assign ram_addr  = ram_mfa ? addr_q : '0;
    assign ram_wdata = ram_mfa ? wdata_q : '0;
    assign if_done   = state_q == RESP && owner_q == 2'b01;
    assign dm_done   = state_q == RESP && owner_q == 2'b10;
    assign if_rdata  = if_done ? rdata_q : '0;
    assign dm_rdata  = dm_done ? rdata_q : '0;
    assign if_err    = if_done & err_q;
    assign dm_err    = dm_done & err_q;
    assign owner     = owner_q;
endmodule
